// File: rtl/udp_tx_conn_resolver_pkg.sv
// Shared types and constants for the TX connection resolver and its helpers.
package udp_tx_conn_resolver_pkg;

    localparam int IP_HDR_BYTES  = 20;
    localparam int UDP_HDR_BYTES = 8;

    localparam logic [15:0] IP_UDP_OVERHEAD = 16'(IP_HDR_BYTES + UDP_HDR_BYTES);
    localparam logic [15:0] UDP_OVERHEAD    = 16'(UDP_HDR_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LKUP_REQ  = 2'd1,
        ST_LKUP_WAIT = 2'd2,
        ST_EMIT      = 2'd3
    } tx_resolver_state_t;

    typedef struct packed {
        logic        hit;
        logic [47:0] mac;
        logic [15:0] udpPort;
        logic [31:0] ip;
    } rv_lookup_rsp_t;

    // Connection-ID width: 16 bits of index plus the way number.
    function automatic int conn_id_width(input int ways);
        return 16 + $clog2(ways);
    endfunction

endpackage

// File: rtl/udp_tx_conn_resolver_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module udp_tx_conn_resolver_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    assign count = r_count;

    // Count one event per cycle, holding once the maximum is reached
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= {W{1'b0}};
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/udp_tx_conn_resolver.sv
// Resolves a send request's connection ID into a header descriptor via the
// connection manager's reverse lookup; one request in flight at a time.
module udp_tx_conn_resolver
    import udp_tx_conn_resolver_pkg::*;
#(
    parameter  int WAYS        = 4,
    parameter  int MAX_PAYLOAD = 1472,
    localparam int CIDW        = conn_id_width(WAYS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_req_valid,
    output logic            s_req_ready,
    input  logic [CIDW-1:0] s_req_connectionId,
    input  logic [15:0]     s_req_length,
    output logic            m_rv_lookup_valid,
    input  logic            m_rv_lookup_ready,
    output logic [CIDW-1:0] m_rv_lookup_connectionId,
    input  logic            s_rv_lookup_valid,
    output logic            s_rv_lookup_ready,
    input  logic            s_rv_lookup_hit,
    input  logic [47:0]     s_rv_lookup_macAddr,
    input  logic [31:0]     s_rv_lookup_ipAddr,
    input  logic [15:0]     s_rv_lookup_udpPort,
    output logic            m_hdr_valid,
    input  logic            m_hdr_ready,
    output logic [47:0]     m_hdr_macAddr,
    output logic [31:0]     m_hdr_ipAddr,
    output logic [15:0]     m_hdr_udpPort,
    output logic [CIDW-1:0] m_hdr_connectionId,
    output logic [15:0]     m_hdr_ipTotalLen,
    output logic [15:0]     m_hdr_udpLen,
    output logic [31:0]     stat_sent,
    output logic [31:0]     stat_miss,
    output logic [31:0]     stat_lenerr
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    // Keeps payload + 28 inside 16 bits.
    if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 65507) begin : g_bad_max_payload
        $error("MAX_PAYLOAD must be within 1..65507");
    end

    tx_resolver_state_t r_state;
    logic               r_req_ready;
    logic               r_rv_ready;
    logic               r_lkup_valid;
    logic               r_hdr_valid;
    logic [CIDW-1:0]    r_req_id;
    logic [15:0]        r_req_len;
    logic [47:0]        r_hdr_mac;
    logic [31:0]        r_hdr_ip;
    logic [15:0]        r_hdr_port;
    logic [CIDW-1:0]    r_hdr_id;
    logic [15:0]        r_hdr_iplen;
    logic [15:0]        r_hdr_udplen;

    rv_lookup_rsp_t     w_rsp;
    logic               w_req_fire;
    logic               w_len_bad;
    logic               w_lenerr_inc;
    logic               w_miss_inc;
    logic               w_sent_inc;

    assign w_rsp = '{hit: s_rv_lookup_hit, mac: s_rv_lookup_macAddr,
                     udpPort: s_rv_lookup_udpPort, ip: s_rv_lookup_ipAddr};

    assign w_req_fire   = s_req_valid && r_req_ready;
    assign w_len_bad    = (s_req_length == 16'd0) || (s_req_length > MAX_LEN);
    assign w_lenerr_inc = w_req_fire && w_len_bad;
    assign w_miss_inc   = (r_state == ST_LKUP_WAIT) && s_rv_lookup_valid && !w_rsp.hit;
    assign w_sent_inc   = r_hdr_valid && m_hdr_ready;

    // Request/lookup/emit sequencing; readies are registered so they track the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_rv_ready   <= 1'b1;
            r_lkup_valid <= 1'b0;
            r_hdr_valid  <= 1'b0;
            r_req_id     <= {CIDW{1'b0}};
            r_req_len    <= 16'd0;
            r_hdr_mac    <= 48'd0;
            r_hdr_ip     <= 32'd0;
            r_hdr_port   <= 16'd0;
            r_hdr_id     <= {CIDW{1'b0}};
            r_hdr_iplen  <= 16'd0;
            r_hdr_udplen <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_fire) begin
                        r_req_id  <= s_req_connectionId;
                        r_req_len <= s_req_length;
                        if (!w_len_bad) begin
                            r_state      <= ST_LKUP_REQ;
                            r_req_ready  <= 1'b0;
                            r_rv_ready   <= 1'b0;
                            r_lkup_valid <= 1'b1;
                        end
                    end
                end
                ST_LKUP_REQ: begin
                    if (m_rv_lookup_ready) begin
                        r_lkup_valid <= 1'b0;
                        r_rv_ready   <= 1'b1;
                        r_state      <= ST_LKUP_WAIT;
                    end
                end
                ST_LKUP_WAIT: begin
                    if (s_rv_lookup_valid) begin
                        if (w_rsp.hit) begin
                            r_hdr_mac    <= w_rsp.mac;
                            r_hdr_ip     <= w_rsp.ip;
                            r_hdr_port   <= w_rsp.udpPort;
                            r_hdr_id     <= r_req_id;
                            r_hdr_iplen  <= r_req_len + IP_UDP_OVERHEAD;
                            r_hdr_udplen <= r_req_len + UDP_OVERHEAD;
                            r_hdr_valid  <= 1'b1;
                            r_rv_ready   <= 1'b0;
                            r_state      <= ST_EMIT;
                        end else begin
                            r_req_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                ST_EMIT: begin
                    if (m_hdr_ready) begin
                        r_hdr_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_rv_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_rv_ready   <= 1'b1;
                    r_lkup_valid <= 1'b0;
                    r_hdr_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign s_req_ready              = r_req_ready;
    assign s_rv_lookup_ready        = r_rv_ready;
    assign m_rv_lookup_valid        = r_lkup_valid;
    assign m_rv_lookup_connectionId = r_req_id;
    assign m_hdr_valid              = r_hdr_valid;
    assign m_hdr_macAddr            = r_hdr_mac;
    assign m_hdr_ipAddr             = r_hdr_ip;
    assign m_hdr_udpPort            = r_hdr_port;
    assign m_hdr_connectionId       = r_hdr_id;
    assign m_hdr_ipTotalLen         = r_hdr_iplen;
    assign m_hdr_udpLen             = r_hdr_udplen;

    udp_tx_conn_resolver_sat_counter #(.W(32)) u_stat_sent (
        .clk(clk), .rst(rst), .inc(w_sent_inc), .clr(1'b0), .count(stat_sent)
    );

    udp_tx_conn_resolver_sat_counter #(.W(32)) u_stat_miss (
        .clk(clk), .rst(rst), .inc(w_miss_inc), .clr(1'b0), .count(stat_miss)
    );

    udp_tx_conn_resolver_sat_counter #(.W(32)) u_stat_lenerr (
        .clk(clk), .rst(rst), .inc(w_lenerr_inc), .clr(1'b0), .count(stat_lenerr)
    );

endmodule

// File: tb/tb_udp_tx_conn_resolver.sv
// Directed bench: a behavioural connection manager and descriptor model check the resolver.
module tb_udp_tx_conn_resolver;

    localparam int CIDW = 18;

    logic            clk;
    logic            rst;
    logic            s_req_valid;
    logic            s_req_ready;
    logic [CIDW-1:0] s_req_connectionId;
    logic [15:0]     s_req_length;
    logic            m_rv_lookup_valid;
    logic            m_rv_lookup_ready;
    logic [CIDW-1:0] m_rv_lookup_connectionId;
    logic            s_rv_lookup_valid;
    logic            s_rv_lookup_ready;
    logic            s_rv_lookup_hit;
    logic [47:0]     s_rv_lookup_macAddr;
    logic [31:0]     s_rv_lookup_ipAddr;
    logic [15:0]     s_rv_lookup_udpPort;
    logic            m_hdr_valid;
    logic            m_hdr_ready;
    logic [47:0]     m_hdr_macAddr;
    logic [31:0]     m_hdr_ipAddr;
    logic [15:0]     m_hdr_udpPort;
    logic [CIDW-1:0] m_hdr_connectionId;
    logic [15:0]     m_hdr_ipTotalLen;
    logic [15:0]     m_hdr_udpLen;
    logic [31:0]     stat_sent;
    logic [31:0]     stat_miss;
    logic [31:0]     stat_lenerr;

    udp_tx_conn_resolver dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_connectionId(s_req_connectionId), .s_req_length(s_req_length),
        .m_rv_lookup_valid(m_rv_lookup_valid), .m_rv_lookup_ready(m_rv_lookup_ready),
        .m_rv_lookup_connectionId(m_rv_lookup_connectionId),
        .s_rv_lookup_valid(s_rv_lookup_valid), .s_rv_lookup_ready(s_rv_lookup_ready),
        .s_rv_lookup_hit(s_rv_lookup_hit), .s_rv_lookup_macAddr(s_rv_lookup_macAddr),
        .s_rv_lookup_ipAddr(s_rv_lookup_ipAddr), .s_rv_lookup_udpPort(s_rv_lookup_udpPort),
        .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
        .m_hdr_macAddr(m_hdr_macAddr), .m_hdr_ipAddr(m_hdr_ipAddr),
        .m_hdr_udpPort(m_hdr_udpPort), .m_hdr_connectionId(m_hdr_connectionId),
        .m_hdr_ipTotalLen(m_hdr_ipTotalLen), .m_hdr_udpLen(m_hdr_udpLen),
        .stat_sent(stat_sent), .stat_miss(stat_miss), .stat_lenerr(stat_lenerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic note(input bit ok, input string name, input string detail);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s %s", name, detail);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        note(act === exp, name, $sformatf("got=%0h want=%0h", act, exp));
    endtask

    // Bound connections: {hit, mac, ip, port}
    function automatic logic [96:0] conn_table(input logic [CIDW-1:0] id);
        case (id)
            18'h00012: return {1'b1, 48'h0200_0000_0001, 32'h0A00_0002, 16'd5000};
            18'h00003: return {1'b1, 48'h0200_0000_0002, 32'h0A00_0003, 16'd6000};
            default:   return {1'b0, 48'h0, 32'h0, 16'h0};
        endcase
    endfunction

    function automatic logic [159:0] pack_hdr(input logic [47:0] mac, input logic [31:0] ip,
                                              input logic [15:0] port, input logic [CIDW-1:0] id,
                                              input logic [15:0] iplen, input logic [15:0] udplen);
        return {14'd0, mac, ip, port, id, iplen, udplen};
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input int b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Connection manager model: answers each lookup after rsp_lat cycles
    int rsp_lat   = 1;
    bit mgr_hold  = 1'b0;
    int lookups   = 0;
    int stale_req = 0;

    initial begin : mgr
        int              wait_cnt;
        int              stale_done;
        bit              drop_next;
        logic [CIDW-1:0] id_q;
        wait_cnt   = -1;
        stale_done = 0;
        drop_next  = 1'b0;
        id_q       = '0;
        s_rv_lookup_valid   = 1'b0;
        s_rv_lookup_hit     = 1'b0;
        s_rv_lookup_macAddr = 48'd0;
        s_rv_lookup_ipAddr  = 32'd0;
        s_rv_lookup_udpPort = 16'd0;
        forever begin
            @(negedge clk);
            if (drop_next) begin
                s_rv_lookup_valid = 1'b0;
                drop_next = 1'b0;
            end
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    {s_rv_lookup_hit, s_rv_lookup_macAddr, s_rv_lookup_ipAddr,
                     s_rv_lookup_udpPort} = conn_table(id_q);
                    s_rv_lookup_valid = 1'b1;
                    wait_cnt = -1;
                end
            end
            if (m_rv_lookup_valid && m_rv_lookup_ready) begin
                lookups++;
                if (!mgr_hold) begin
                    id_q = m_rv_lookup_connectionId;
                    wait_cnt = rsp_lat;
                end
            end
            if (stale_req != stale_done) begin
                stale_done = stale_req;
                s_rv_lookup_hit     = 1'b1;
                s_rv_lookup_macAddr = 48'hDEAD_BEEF_0001;
                s_rv_lookup_ipAddr  = 32'hC0A8_0001;
                s_rv_lookup_udpPort = 16'd1234;
                s_rv_lookup_valid   = 1'b1;
            end
            if (s_rv_lookup_valid && s_rv_lookup_ready) drop_next = 1'b1;
        end
    end

    // Expected descriptors in emission order; hs_count indexes the one due next
    logic [159:0] exp_q[$];
    int           hs_count = 0;

    initial begin : cmp
        forever begin
            @(negedge clk);
            if (!rst && m_hdr_valid) begin
                if (hs_count < exp_q.size()) begin
                    note(pack_hdr(m_hdr_macAddr, m_hdr_ipAddr, m_hdr_udpPort, m_hdr_connectionId,
                                  m_hdr_ipTotalLen, m_hdr_udpLen) === exp_q[hs_count],
                         "hdr_fields",
                         $sformatf("got=%0h want=%0h",
                                   pack_hdr(m_hdr_macAddr, m_hdr_ipAddr, m_hdr_udpPort,
                                            m_hdr_connectionId, m_hdr_ipTotalLen, m_hdr_udpLen),
                                   exp_q[hs_count]));
                end else begin
                    chk("hdr_unexpected", 64'(m_hdr_valid), 64'd0);
                end
                chk("req_ready_while_emit", 64'(s_req_ready), 64'd0);
                if (m_hdr_ready) hs_count++;
            end
        end
    end

    logic [31:0] exp_miss;
    logic [31:0] exp_lenerr;
    logic [31:0] sent_base;
    int          hs_mark;
    int          exp_lookups;

    task automatic send_req(input logic [CIDW-1:0] id, input logic [15:0] len);
        logic [96:0] ent;
        bit          acc;
        acc = 1'b0;
        s_req_valid        = 1'b1;
        s_req_connectionId = id;
        s_req_length       = len;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = s_req_ready;
            @(posedge clk);
            #1;
        end
        s_req_valid = 1'b0;
        chk("req_accept", 64'(acc), 64'd1);
        if (acc) begin
            ent = conn_table(id);
            if (len == 16'd0 || len > 16'd1472) begin
                exp_lenerr = sat_add(exp_lenerr, 1);
            end else begin
                exp_lookups++;
                if (ent[96]) exp_q.push_back(pack_hdr(ent[95:48], ent[47:16], ent[15:0], id,
                                                      len + 16'd28, len + 16'd8));
                else exp_miss = sat_add(exp_miss, 1);
            end
        end
    endtask

    task automatic wait_hdr(output int cyc);
        cyc = 0;
        while (!m_hdr_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (s_req_ready && !m_hdr_valid && !m_rv_lookup_valid && hs_count == exp_q.size())
                done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("idle_reached", 64'(done), 64'd1);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_sent"},    64'(stat_sent),   64'(sat_add(sent_base, hs_count - hs_mark)));
        chk({tag, "_miss"},    64'(stat_miss),   64'(exp_miss));
        chk({tag, "_lenerr"},  64'(stat_lenerr), 64'(exp_lenerr));
        chk({tag, "_lookups"}, 64'(lookups),     64'(exp_lookups));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int cyc;
        int hs0;
        int lk0;
        rst = 1'b1;
        s_req_valid = 1'b0;
        s_req_connectionId = '0;
        s_req_length = 16'd0;
        m_rv_lookup_ready = 1'b1;
        m_hdr_ready = 1'b1;
        exp_miss = 32'd0;
        exp_lenerr = 32'd0;
        sent_base = 32'd0;
        hs_mark = 0;
        exp_lookups = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(s_req_ready), 64'd1);
        chk("rst_rv_ready", 64'(s_rv_lookup_ready), 64'd1);
        chk("rst_valids", 64'({m_rv_lookup_valid, m_hdr_valid}), 64'd0);
        chk("rst_stats", 64'(stat_sent | stat_miss | stat_lenerr), 64'd0);
        chk("rst_data", 64'({m_hdr_ipTotalLen, m_hdr_udpLen, m_hdr_udpPort}), 64'd0);
        rst = 1'b0;

        // Bound ID 0x00012, len 100
        send_req(18'h00012, 16'd100);
        wait_hdr(cyc);
        chk("t1_latency", 64'(cyc), 64'd2);
        chk("t1_iplen_lit", 64'(m_hdr_ipTotalLen), 64'd128);
        chk("t1_udplen_lit", 64'(m_hdr_udpLen), 64'd108);
        chk("t1_mac_lit", 64'(m_hdr_macAddr), 64'h0200_0000_0001);
        chk("t1_ip_lit", 64'(m_hdr_ipAddr), 64'h0A00_0002);
        wait_idle();
        check_stats("t1");
        chk("t1_sent_lit", 64'(stat_sent), 64'd1);

        // Unbound ID: lookup miss
        send_req(18'h00007, 16'd64);
        wait_idle();
        check_stats("t2");
        chk("t2_miss_lit", 64'(stat_miss), 64'd1);
        chk("t2_req_ready", 64'(s_req_ready), 64'd1);

        // Illegal lengths: no lookup
        send_req(18'h00012, 16'd0);
        send_req(18'h00012, 16'd1473);
        wait_idle();
        check_stats("t3");
        chk("t3_lenerr_lit", 64'(stat_lenerr), 64'd2);

        // Max length under backpressure, slower manager
        rsp_lat = 3;
        m_hdr_ready = 1'b0;
        send_req(18'h00003, 16'd1472);
        wait_hdr(cyc);
        chk("t4_latency", 64'(cyc), 64'd4);
        chk("t4_udplen_lit", 64'(m_hdr_udpLen), 64'd1480);
        hs0 = hs_count;
        repeat (20) @(posedge clk);
        #1;
        chk("t4_hold_valid", 64'(m_hdr_valid), 64'd1);
        chk("t4_hold_no_hs", 64'(hs_count - hs0), 64'd0);
        m_hdr_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t4_hs_once", 64'(hs_count - hs0), 64'd1);
        wait_idle();
        check_stats("t4");

        // Reset while waiting for the lookup response, then a stale response
        rsp_lat = 1;
        mgr_hold = 1'b1;
        lk0 = lookups;
        send_req(18'h00012, 16'd200);
        for (int i = 0; i < 20 && lookups == lk0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_lookup_issued", 64'(lookups - lk0), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        exp_miss = 32'd0;
        exp_lenerr = 32'd0;
        sent_base = 32'd0;
        hs_mark = hs_count;
        chk("t5_valids_dropped", 64'({m_rv_lookup_valid, m_hdr_valid}), 64'd0);
        check_stats("t5_rst");
        mgr_hold = 1'b0;
        stale_req++;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_stale_consumed", 64'(s_rv_lookup_valid), 64'd0);
        check_stats("t5_stale");
        send_req(18'h00012, 16'd200);
        wait_idle();
        check_stats("t5_next");
        chk("t5_sent_lit", 64'(stat_sent), 64'd1);

        // Saturation of the sent counter
        force dut.u_stat_sent.r_count = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.u_stat_sent.r_count;
        sent_base = 32'hFFFF_FFFF;
        hs_mark = hs_count;
        chk("t6_preset", 64'(stat_sent), 64'hFFFF_FFFF);
        send_req(18'h00003, 16'd1);
        wait_idle();
        check_stats("t6");
        chk("t6_sat_lit", 64'(stat_sent), 64'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
